// File: rtl/game_timer_bcd_pkg.sv
// rtl/game_timer_bcd_pkg.sv - shared types, widths and BCD step helper for the game timer
package game_timer_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int TENS_W  = 3;
    localparam int UNITS_W = 4;
    localparam int TIME_W  = TENS_W + UNITS_W;

    localparam logic [TIME_W-1:0] END_UP   = 7'h79;
    localparam logic [TIME_W-1:0] END_DOWN = 7'h00;

    // One-second step on packed BCD; digits are handled separately so units stay 0..9.
    function automatic logic [TIME_W-1:0] bcd_step(input logic [TIME_W-1:0] v, input logic down);
        logic [TENS_W-1:0]  t;
        logic [UNITS_W-1:0] u;
        t = v[TIME_W-1:UNITS_W];
        u = v[UNITS_W-1:0];
        if (down) begin
            if (u != 4'd0) begin
                u = u - 4'd1;
            end else begin
                u = 4'd9;
                t = t - 3'd1;
            end
        end else begin
            if (u != 4'd9) begin
                u = u + 4'd1;
            end else begin
                u = 4'd0;
                t = t + 3'd1;
            end
        end
        return {t, u};
    endfunction

endpackage

// File: rtl/game_timer_bcd_tick_gen.sv
// rtl/game_timer_bcd_tick_gen.sv - one-second prescaler with enable and synchronous clear
module game_timer_bcd_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick only when the counter is allowed to advance, so a held count keeps its partial second.
    assign tick = en && (cnt_q == LAST);

    // Next prescaler value: clear wins, otherwise wrap at LAST while enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - BCD seconds counter with start/pause/clear/game_over control
module game_timer_bcd
    import game_timer_bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter bit          COUNT_DOWN  = 1'b1,
    parameter logic [2:0]  START_TENS  = 3'd6,
    parameter logic [3:0]  START_UNITS = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       game_over,
    output logic [6:0] dout_time,
    output logic       running,
    output logic       time_up
);

    localparam logic [TIME_W-1:0] INIT    = COUNT_DOWN ? {START_TENS, START_UNITS} : 7'h00;
    localparam logic [TIME_W-1:0] END_VAL = COUNT_DOWN ? END_DOWN : END_UP;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] dout_q, dout_d;
    logic              running_q, running_d;
    logic              time_up_q, time_up_d;

    logic              tick;
    logic              tick_en;
    logic [TIME_W-1:0] step_val;
    logic              step_final;
    logic              at_end;

    // Pause/start/clear outrank the tick, so the prescaler does not advance on those cycles.
    assign tick_en    = (state_q == ST_RUN) && !pause && !start && !clear;
    assign step_val   = bcd_step(dout_q, COUNT_DOWN);
    assign step_final = (step_val == END_VAL);
    // Only reachable by starting at the end value (e.g. a 00 countdown preset).
    assign at_end     = (dout_q == END_VAL);

    game_timer_bcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (start | clear),
        .tick  (tick)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dout_q    <= INIT;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            running_q <= running_d;
            time_up_q <= time_up_d;
        end
    end

    // Next state; priority clear > start > game_over > pause > tick.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (at_end || game_over) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick && step_final) begin
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (game_over) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Next outputs: time value, end-of-count pulse, and running lagging state by one register.
    always_comb begin
        dout_d    = dout_q;
        time_up_d = 1'b0;
        running_d = (state_q == ST_RUN);
        if (clear || start) begin
            dout_d = INIT;
        end else if (state_q == ST_RUN) begin
            if (at_end) begin
                time_up_d = 1'b1;
            end else if (game_over) begin
                // A final tick landing with game_over still completes the count.
                if (tick && step_final) begin
                    dout_d    = step_val;
                    time_up_d = 1'b1;
                end
            end else if (!pause && tick) begin
                dout_d    = step_val;
                time_up_d = step_final;
            end
        end
    end

    assign dout_time = dout_q;
    assign running   = running_q;
    assign time_up   = time_up_q;

endmodule

// File: tb/tb_game_timer_bcd.sv
// tb/tb_game_timer_bcd.sv - scoreboard bench for countdown and count-up timer instances
module tb_game_timer_bcd;

    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, pause = 1'b0, clear = 1'b0, game_over = 1'b0;
    logic [6:0] dout_dn, dout_up;
    logic run_dn, run_up, tu_dn, tu_up;
    logic go = 1'b0;

    always #5 clk = ~clk;

    game_timer_bcd #(.TICK_DIV(DIV), .COUNT_DOWN(1'b1), .START_TENS(3'd6), .START_UNITS(4'd0)) dut_dn (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
        .game_over(game_over), .dout_time(dout_dn), .running(run_dn), .time_up(tu_dn));

    game_timer_bcd #(.TICK_DIV(DIV), .COUNT_DOWN(1'b0), .START_TENS(3'd6), .START_UNITS(4'd0)) dut_up (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
        .game_over(game_over), .dout_time(dout_up), .running(run_up), .time_up(tu_up));

    typedef struct packed {
        logic [6:0] t;
        logic       r;
        logic       u;
    } exp_t;

    exp_t sb_dn[$];
    exp_t sb_up[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model: index 0 = countdown instance, 1 = count-up instance; time kept as integer seconds.
    int mode[2];
    int secs[2];
    int phase[2];

    function automatic int init_secs(input int k);
        return (k == 0) ? 60 : 0;
    endfunction

    function automatic int end_secs(input int k);
        return (k == 0) ? 0 : 79;
    endfunction

    function automatic int next_secs(input int k, input int v);
        return (k == 0) ? v - 1 : v + 1;
    endfunction

    function automatic logic [6:0] to_bcd(input int v);
        logic [2:0] t;
        logic [3:0] u;
        t = 3'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got time=%h running=%b time_up=%b, expected time=%h running=%b time_up=%b",
                     name, $time, got.t, got.r, got.u, want.t, want.r, want.u);
        end
    endtask

    exp_t e;
    bit   was_run;
    bit   tu;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mode[k]  = M_IDLE;
                secs[k]  = init_secs(k);
                phase[k] = 0;
                e = {to_bcd(init_secs(k)), 1'b0, 1'b0};
                if (k == 0) begin
                    sb_dn.delete();
                    sb_dn.push_back(e);
                end else begin
                    sb_up.delete();
                    sb_up.push_back(e);
                end
            end else begin
                was_run = (mode[k] == M_RUN);
                tu = 1'b0;
                if (clear) begin
                    mode[k] = M_IDLE; secs[k] = init_secs(k); phase[k] = 0;
                end else if (start) begin
                    mode[k] = M_RUN; secs[k] = init_secs(k); phase[k] = 0;
                end else if (mode[k] == M_RUN) begin
                    if (secs[k] == end_secs(k)) begin
                        mode[k] = M_DONE; tu = 1'b1;
                    end else if (game_over) begin
                        if (phase[k] == DIV - 1 && next_secs(k, secs[k]) == end_secs(k)) begin
                            secs[k] = next_secs(k, secs[k]); tu = 1'b1;
                        end
                        mode[k] = M_DONE;
                    end else if (pause) begin
                        mode[k] = M_PAUSE;
                    end else begin
                        phase[k]++;
                        if (phase[k] == DIV) begin
                            phase[k] = 0;
                            secs[k] = next_secs(k, secs[k]);
                            if (secs[k] == end_secs(k)) begin
                                mode[k] = M_DONE; tu = 1'b1;
                            end
                        end
                    end
                end else if (mode[k] == M_PAUSE) begin
                    if (game_over) mode[k] = M_DONE;
                    else if (pause) mode[k] = M_RUN;
                end
                e = {to_bcd(secs[k]), was_run, tu};
                if (k == 0) sb_dn.push_back(e);
                else        sb_up.push_back(e);
            end
        end
    end

    // Monitor: scoreboard pops on falling clk; a reset asserted while clk is high is checked 1 ns later.
    always @(negedge clk or negedge rst_n) begin
        if (clk) begin
            #1;
            check("reset_now_dn", {dout_dn, run_dn, tu_dn}, {7'h60, 1'b0, 1'b0});
            check("reset_now_up", {dout_up, run_up, tu_up}, {7'h00, 1'b0, 1'b0});
        end else begin
            if (sb_dn.size() > 0) check("down", {dout_dn, run_dn, tu_dn}, sb_dn.pop_front());
            if (sb_up.size() > 0) check("up",   {dout_up, run_up, tu_up}, sb_up.pop_front());
        end
    end

    task automatic cyc(input bit s, input bit p, input bit c, input bit g);
        @(negedge clk);
        start = s; pause = p; clear = c; game_over = g;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0; pause = 1'b0; clear = 1'b0; game_over = 1'b0;
        go = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        cyc(1, 0, 0, 0); idle(4 * 79 + 8);
        cyc(0, 0, 1, 0); idle(3);
        cyc(1, 0, 0, 0); idle(5); cyc(0, 1, 0, 0); idle(20); cyc(0, 1, 0, 0); idle(12);
        cyc(1, 0, 0, 0); idle(72); cyc(0, 0, 0, 1); idle(5);
        cyc(0, 0, 1, 0); idle(3); cyc(1, 0, 1, 0); idle(6);
        cyc(0, 1, 0, 0); idle(3);
        cyc(1, 0, 0, 0); idle(239); cyc(0, 0, 0, 1); idle(4);
        cyc(1, 0, 0, 0); idle(110); do_reset(); idle(3);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 99) == 0) go = ~go;
                cyc(r < 7, (r >= 10) && (r < 40), (r >= 7) && (r < 10), go);
            end
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
